// File: rtl/connect_pkg.sv
// Shared types and cell codes for the Connect4 win detector.
package connect_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_P1    = 2'b01;
   localparam logic [1:0] CELL_P2    = 2'b10;

   typedef enum logic [1:0] {
      WIN_H  = 2'b00,
      WIN_V  = 2'b01,
      WIN_DU = 2'b10,
      WIN_DD = 2'b11
   } win_kind_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SCAN  = 2'b01,
      ST_DRAIN = 2'b10,
      ST_DONE  = 2'b11
   } check_state_t;

endpackage

// File: rtl/connect_n_checker_if.sv
// Controller / board-RAM side of the win detector, bundled as one interface.
interface connect_n_checker_if #(
   parameter int ROWS   = 8,
   parameter int COLS   = 8,
   parameter int ADDR_W = $clog2(ROWS)
);
   logic                check_en;
   logic [1:0]          player;
   logic [2*COLS-1:0]   ram_r_val;
   logic [ADDR_W-1:0]   check_addr;
   logic                check_r_en;
   logic                check_win;
   logic [ADDR_W-1:0]   win_row;
   logic [1:0]          win_kind;
   logic                finished;

   modport master (
      output check_en, player, ram_r_val,
      input  check_addr, check_r_en, check_win, win_row, win_kind, finished
   );

   modport slave (
      input  check_en, player, ram_r_val,
      output check_addr, check_r_en, check_win, win_row, win_kind, finished
   );
endinterface

// File: rtl/connect_window_eval.sv
// Combinational line detector for one arriving row mask against the row history.
// Diagonal detectors are built only when CONNECT_DIAG_EN is defined.
module connect_window_eval
   import connect_pkg::*;
#(
   parameter int COLS    = 8,
   parameter int WIN_LEN = 4
) (
   input  logic [COLS-1:0]                 mask,
   input  logic [WIN_LEN-2:0][COLS-1:0]    hist,
   input  logic                            hist_full,
   output logic [3:0]                      hit_flags,
   output win_kind_t                       kind
);

   logic [COLS-1:0] acc_h_s;
   logic [COLS-1:0] acc_v_s;
   logic            hit_h_s;
   logic            hit_v_s;
   logic            hit_du_s;
   logic            hit_dd_s;

   // Bit c of acc_h_s survives only if cells c..c+WIN_LEN-1 all match; acc_v_s stacks columns.
   always_comb begin
      acc_h_s = mask;
      acc_v_s = mask;
      for (int i = 1; i < WIN_LEN; i++) begin
         acc_h_s = acc_h_s & (mask >> i);
         acc_v_s = acc_v_s & hist[i-1];
      end
   end

   assign hit_h_s = |acc_h_s;
   assign hit_v_s = hist_full & (|acc_v_s);

`ifdef CONNECT_DIAG_EN
   logic [COLS-1:0] acc_du_s;
   logic [COLS-1:0] acc_dd_s;

   // Shifting older masks aligns column c-i (rising) or c+i (falling); shifted-in zeros never match.
   always_comb begin
      acc_du_s = mask;
      acc_dd_s = mask;
      for (int i = 1; i < WIN_LEN; i++) begin
         acc_du_s = acc_du_s & (hist[i-1] << i);
         acc_dd_s = acc_dd_s & (hist[i-1] >> i);
      end
   end

   assign hit_du_s = hist_full & (|acc_du_s);
   assign hit_dd_s = hist_full & (|acc_dd_s);
`else
   assign hit_du_s = 1'b0;
   assign hit_dd_s = 1'b0;
`endif

   assign hit_flags = {hit_dd_s, hit_du_s, hit_v_s, hit_h_s};

   // Priority encode the reported kind.
   always_comb begin
      if (hit_h_s) begin
         kind = WIN_H;
      end else if (hit_v_s) begin
         kind = WIN_V;
      end else if (hit_du_s) begin
         kind = WIN_DU;
      end else if (hit_dd_s) begin
         kind = WIN_DD;
      end else begin
         kind = WIN_H;
      end
   end

endmodule

// File: rtl/connect_n_checker.sv
// Connect4 win detector: scans the board one row per cycle and reports the first line found.
// Define CONNECT_DIAG_EN to add the two diagonal detectors.
module connect_n_checker
   import connect_pkg::*;
#(
   parameter int ROWS    = 8,
   parameter int COLS    = 8,
   parameter int WIN_LEN = 4,
   parameter int ADDR_W  = $clog2(ROWS)
) (
   input  logic                clk,
   input  logic                rst_n,
   connect_n_checker_if.slave  bus
);

   localparam int CNT_W = $clog2(WIN_LEN);
   localparam logic [CNT_W-1:0]  HIST_FULL = CNT_W'(WIN_LEN - 1);
   localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(ROWS - 1);

   if (WIN_LEN < 2 || WIN_LEN > ROWS || WIN_LEN > COLS) begin : g_bad_win_len
      $error("connect_n_checker: WIN_LEN must lie in 2..min(ROWS,COLS)");
   end

   check_state_t                  state_r;
   logic [ADDR_W-1:0]             addr_r;
   logic                          rd_en_r;
   logic                          data_vld_r;
   logic [ADDR_W-1:0]             data_row_r;
   logic [1:0]                    player_r;
   logic [WIN_LEN-2:0][COLS-1:0]  hist_r;
   logic [CNT_W-1:0]              hist_cnt_r;
   logic                          win_r;
   logic [ADDR_W-1:0]             win_row_r;
   win_kind_t                     win_kind_r;
   logic                          finished_r;

   logic [COLS-1:0]               mask_s;
   logic                          hist_full_s;
   logic [3:0]                    hit_flags_s;
   win_kind_t                     kind_s;
   logic                          eval_s;
   logic                          hit_s;

   // Codes 00 and 11 are not players, so such a search yields an all-zero mask.
   function automatic logic [COLS-1:0] row_mask(input logic [2*COLS-1:0] row,
                                                input logic [1:0] who);
      logic [COLS-1:0] m;
      m = {COLS{1'b0}};
      for (int c = 0; c < COLS; c++) begin
         m[c] = (row[2*c +: 2] == who) && ((who == CELL_P1) || (who == CELL_P2));
      end
      return m;
   endfunction

   assign mask_s      = row_mask(bus.ram_r_val, player_r);
   assign hist_full_s = (hist_cnt_r == HIST_FULL);
   assign eval_s      = data_vld_r && ((state_r == ST_SCAN) || (state_r == ST_DRAIN));
   assign hit_s       = eval_s && (|hit_flags_s);

   connect_window_eval #(
      .COLS    (COLS),
      .WIN_LEN (WIN_LEN)
   ) u_eval (
      .mask      (mask_s),
      .hist      (hist_r),
      .hist_full (hist_full_s),
      .hit_flags (hit_flags_s),
      .kind      (kind_s)
   );

   // Read pipeline tag: which row, if any, is on ram_r_val this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_vld_r <= 1'b0;
         data_row_r <= {ADDR_W{1'b0}};
      end else begin
         data_vld_r <= rd_en_r;
         data_row_r <= addr_r;
      end
   end

   // Scan FSM with address counter, row history and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         addr_r     <= {ADDR_W{1'b0}};
         rd_en_r    <= 1'b0;
         player_r   <= CELL_EMPTY;
         hist_r     <= '0;
         hist_cnt_r <= {CNT_W{1'b0}};
         win_r      <= 1'b0;
         win_row_r  <= {ADDR_W{1'b0}};
         win_kind_r <= WIN_H;
         finished_r <= 1'b0;
      end else begin
         finished_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.check_en) begin
                  state_r    <= ST_SCAN;
                  player_r   <= bus.player;
                  addr_r     <= {ADDR_W{1'b0}};
                  rd_en_r    <= 1'b1;
                  hist_r     <= '0;
                  hist_cnt_r <= {CNT_W{1'b0}};
                  win_r      <= 1'b0;
                  win_row_r  <= {ADDR_W{1'b0}};
                  win_kind_r <= WIN_H;
               end else begin
                  rd_en_r <= 1'b0;
               end
            end
            ST_SCAN, ST_DRAIN: begin
               if (hit_s) begin
                  win_r      <= 1'b1;
                  win_row_r  <= data_row_r;
                  win_kind_r <= kind_s;
                  state_r    <= ST_DONE;
                  finished_r <= 1'b1;
                  rd_en_r    <= 1'b0;
                  addr_r     <= {ADDR_W{1'b0}};
               end else begin
                  if (eval_s) begin
                     hist_r[0] <= mask_s;
                     for (int i = 1; i < WIN_LEN - 1; i++) begin
                        hist_r[i] <= hist_r[i-1];
                     end
                     hist_cnt_r <= hist_full_s ? hist_cnt_r : hist_cnt_r + CNT_W'(1);
                  end else begin
                     hist_cnt_r <= hist_cnt_r;
                  end
                  if (state_r == ST_DRAIN) begin
                     state_r    <= ST_DONE;
                     finished_r <= 1'b1;
                  end else if (addr_r == LAST_ROW) begin
                     state_r <= ST_DRAIN;
                     rd_en_r <= 1'b0;
                     addr_r  <= {ADDR_W{1'b0}};
                  end else begin
                     addr_r <= addr_r + ADDR_W'(1);
                  end
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               rd_en_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.check_addr = addr_r;
   assign bus.check_r_en = rd_en_r;
   assign bus.check_win  = win_r;
   assign bus.win_row    = win_row_r;
   assign bus.win_kind   = win_kind_r;
   assign bus.finished   = finished_r;

endmodule

// File: tb/tb_connect_n_checker.sv
// Self-checking bench for connect_n_checker: directed vector table, reset/restart
// sequences and random boards checked against a board-level line-search model.
module tb_connect_n_checker;
   import connect_pkg::*;

   localparam int ROWS = 8;
   localparam int COLS = 8;
   localparam int WL   = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   connect_n_checker_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

   connect_n_checker #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [15:0] board [ROWS];

   // Board RAM: one-cycle read latency, junk when not strobed.
   always @(posedge clk) bus.ram_r_val <= bus.check_r_en ? board[bus.check_addr] : 16'($urandom);

   int checks = 0;
   int fails  = 0;

   task automatic check(input string nm, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   // Reference: a line ends at (r,c) going back k steps by (dr,dc).
   function automatic bit is_p(input int r, input int c, input logic [1:0] p);
      logic [15:0] w;
      if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b0;
      if (p != 2'b01 && p != 2'b10) return 1'b0;
      w = board[r];
      return w[2*c +: 2] == p;
   endfunction

   function automatic bit line_end(input int r, input int c, input int dr, input int dc, input logic [1:0] p);
      for (int k = 0; k < WL; k++) if (!is_p(r - k*dr, c - k*dc, p)) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model(input logic [1:0] p, output bit w, output int row, output logic [1:0] kind);
      bit h, v, du, dd;
      w = 1'b0; row = 0; kind = 2'b00;
      for (int r = 0; r < ROWS && !w; r++) begin
         h = 1'b0; v = 1'b0; du = 1'b0; dd = 1'b0;
         for (int c = 0; c < COLS; c++) begin
            h |= line_end(r, c, 0, 1, p);
            v |= line_end(r, c, 1, 0, p);
`ifdef CONNECT_DIAG_EN
            du |= line_end(r, c, 1, 1, p);
            dd |= line_end(r, c, 1, -1, p);
`endif
         end
         if (h || v || du || dd) begin
            w = 1'b1; row = r;
            kind = h ? 2'b00 : v ? 2'b01 : du ? 2'b10 : 2'b11;
         end
      end
   endtask

   int         fin_cyc, rd_cnt, addr_err;
   logic       ren_fin, pulse_extra, held, got_win;
   logic [2:0] got_row;
   logic [1:0] got_kind;

   // One scan from IDLE; cycle n is the n-th negedge after the start edge.
   task automatic run_scan(input logic [1:0] who);
      @(negedge clk);
      bus.player = who; bus.check_en = 1'b1;
      fin_cyc = -1; rd_cnt = 0; addr_err = 0; ren_fin = 1'b1;
      got_win = 1'bx; got_row = 3'bxxx; got_kind = 2'bxx;
      for (int n = 0; n < 20 && fin_cyc < 0; n++) begin
         @(negedge clk);
         bus.check_en = 1'b0;
         bus.player   = 2'($urandom);
         if (bus.check_r_en) begin
            if (int'(bus.check_addr) != n) addr_err++;
            rd_cnt++;
         end
         if (bus.finished) begin
            fin_cyc = n; ren_fin = bus.check_r_en;
            got_win = bus.check_win; got_row = bus.win_row; got_kind = bus.win_kind;
         end
      end
      @(negedge clk);
      pulse_extra = bus.finished;
      held = (bus.check_win === got_win) && (bus.win_row === got_row) && (bus.win_kind === got_kind);
   endtask

   task automatic apply(input string nm, input logic [1:0] who, input bit ew, input int er, input logic [1:0] ek);
      int ef, erd;
      ef  = ew ? er + 2 : ROWS + 1;
      erd = ew ? ((er + 2 > ROWS) ? ROWS : er + 2) : ROWS;
      run_scan(who);
      check({nm, "/fin_cycle"}, fin_cyc, ef);
      check({nm, "/check_win"}, got_win, ew);
      check({nm, "/win_row"}, got_row, ew ? er : 0);
      check({nm, "/win_kind"}, got_kind, ew ? ek : 2'b00);
      check({nm, "/ren_at_fin"}, ren_fin, 0);
      check({nm, "/reads"}, rd_cnt, erd);
      check({nm, "/addr_order"}, addr_err, 0);
      check({nm, "/pulse_len"}, pulse_extra, 0);
      check({nm, "/held"}, held, 1);
   endtask

   typedef struct {
      logic [15:0] rows [ROWS];
      logic [1:0]  who;
      bit          ew;
      int          er;
      logic [1:0]  ek;
   } vec_t;

   vec_t        vt [9];
   bit          mw;
   int          mr, thr, x, sel, fin_seen, wins_seen;
   logic [1:0]  mk, who, cellv;
   int          pulses [$];

   initial begin
      vt[0] = '{rows: '{16'h0290, 16'h0090, 16'h0010, 16'h0010, 16'h0, 16'h0, 16'h0, 16'h0}, who: 2'b01, ew: 1, er: 3, ek: 2'b01};
      vt[1] = '{rows: '{16'h0, 16'h0, 16'h0055, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, who: 2'b01, ew: 1, er: 2, ek: 2'b00};
`ifdef CONNECT_DIAG_EN
      vt[2] = '{rows: '{16'h0002, 16'h0008, 16'h0020, 16'h0080, 16'h0, 16'h0, 16'h0, 16'h0}, who: 2'b10, ew: 1, er: 3, ek: 2'b10};
`else
      vt[2] = '{rows: '{16'h0002, 16'h0008, 16'h0020, 16'h0080, 16'h0, 16'h0, 16'h0, 16'h0}, who: 2'b10, ew: 0, er: 0, ek: 2'b00};
`endif
      vt[3] = '{rows: '{16'h0010, 16'h0010, 16'h0010, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, who: 2'b01, ew: 0, er: 0, ek: 2'b00};
      vt[4] = '{rows: '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, who: 2'b11, ew: 0, er: 0, ek: 2'b00};
      vt[5] = '{rows: '{16'hAA00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, who: 2'b10, ew: 1, er: 0, ek: 2'b00};
      vt[6] = '{rows: '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0055}, who: 2'b01, ew: 1, er: 7, ek: 2'b00};
      vt[7] = '{rows: '{16'h0115, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, who: 2'b01, ew: 0, er: 0, ek: 2'b00};
      vt[8] = '{rows: '{16'h0001, 16'h0001, 16'h0001, 16'h0055, 16'h0, 16'h0, 16'h0, 16'h0}, who: 2'b01, ew: 1, er: 3, ek: 2'b00};

      bus.check_en = 1'b0; bus.player = 2'b00;
      for (int r = 0; r < ROWS; r++) board[r] = 16'h0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset/check_r_en", bus.check_r_en, 0);
      check("reset/check_addr", bus.check_addr, 0);
      check("reset/check_win", bus.check_win, 0);
      check("reset/win_row", bus.win_row, 0);
      check("reset/win_kind", bus.win_kind, 0);
      check("reset/finished", bus.finished, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         board = vt[i].rows;
         apply($sformatf("vec%0d", i), vt[i].who, vt[i].ew, vt[i].er, vt[i].ek);
      end

      // Reset in cycle 3 of the vertical scan, then restart.
      board = vt[0].rows;
      @(negedge clk);
      bus.player = 2'b01; bus.check_en = 1'b1;
      @(negedge clk);
      bus.check_en = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst/pre_addr", bus.check_addr, 3);
      rst_n = 1'b0;
      #1;
      check("midrst/check_r_en", bus.check_r_en, 0);
      check("midrst/check_addr", bus.check_addr, 0);
      check("midrst/check_win", bus.check_win, 0);
      check("midrst/win_row", bus.win_row, 0);
      check("midrst/win_kind", bus.win_kind, 0);
      check("midrst/finished", bus.finished, 0);
      @(negedge clk);
      rst_n = 1'b1;
      fin_seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.finished) fin_seen++;
      end
      check("midrst/no_finished", fin_seen, 0);
      apply("midrst/restart", 2'b01, 1, 3, 2'b01);

      // Empty board, player 00, check_en held high: back-to-back scans via IDLE.
      for (int r = 0; r < ROWS; r++) board[r] = 16'h0;
      @(negedge clk);
      bus.player = 2'b00; bus.check_en = 1'b1;
      wins_seen = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (bus.check_win) wins_seen++;
         if (bus.finished) pulses.push_back(n);
      end
      bus.check_en = 1'b0;
      check("hold/wins", wins_seen, 0);
      check("hold/pulse_count", pulses.size(), 3);
      for (int k = 0; k < pulses.size(); k++) check($sformatf("hold/pulse%0d", k), pulses[k], 9 + 11*k);
      fin_seen = 0;
      for (int n = 0; n < 20 && fin_seen == 0; n++) begin
         @(negedge clk);
         if (bus.finished) fin_seen = 1;
      end
      check("hold/drain_finish", fin_seen, 1);
      @(negedge clk);

      // Random boards against the line-search model.
      for (int t = 0; t < 40; t++) begin
         thr = $urandom_range(1, 3);
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               x = $urandom_range(0, 9);
               cellv = (x < thr) ? 2'b01 : (x < 2*thr) ? 2'b10 : (x == 9) ? 2'b11 : 2'b00;
               board[r][2*c +: 2] = cellv;
            end
         end
         sel = $urandom_range(0, 11);
         who = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b11 : (sel % 2 == 0) ? 2'b01 : 2'b10;
         model(who, mw, mr, mk);
         apply($sformatf("rand%0d", t), who, mw, mr, mk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
